// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci generator family.
package fib_pkg;

   // Run-control states: idle, streaming terms, one-cycle completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci recurrence step with wrap tracking.
// Shared by the Fibonacci, Lucas and seeded generators.
module fib_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ovf_a,
   input  logic             ovf_b,
   output logic [WIDTH-1:0] next_a,
   output logic [WIDTH-1:0] next_b,
   output logic             next_ovf_a,
   output logic             next_ovf_b
);

   logic [WIDTH:0] w_sum;

   // Extra bit catches the carry that marks a wrapped term.
   assign w_sum      = {1'b0, a} + {1'b0, b};
   assign next_a     = b;
   assign next_b     = w_sum[WIDTH-1:0];
   assign next_ovf_a = ovf_b;
   // A term is wrapped if its own sum carried or either ancestor was wrapped.
   assign next_ovf_b = w_sum[WIDTH] | ovf_a | ovf_b;

endmodule

// File: rtl/fib_seq_gen.sv
// Command-driven Fibonacci term streamer with valid/ready output,
// per-term wrap flag, sticky run overflow and a done pulse.
module fib_seq_gen
   import fib_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] n,
   input  logic [WIDTH-1:0] seed0,
   input  logic [WIDTH-1:0] seed1,
   output logic             busy,
   output logic             term_valid,
   input  logic             term_ready,
   output logic [WIDTH-1:0] term,
   output logic [IDX_W-1:0] term_idx,
   output logic             term_last,
   output logic             term_ovf,
   output logic             done,
   output logic             overflow
);

   fib_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b;
   logic             r_ovf_a, r_ovf_b;
   logic [IDX_W-1:0] r_idx, r_n;
   logic             r_overflow;

   logic             w_run, w_hs, w_at_last, w_start_ok;
   logic [WIDTH-1:0] w_next_a, w_next_b;
   logic             w_next_ovf_a, w_next_ovf_b;

   assign w_run      = (r_state == RUN);
   assign w_start_ok = (r_state == IDLE) & start;
   assign w_hs       = w_run & term_ready;
   assign w_at_last  = (r_idx == r_n);

   fib_step #(.WIDTH(WIDTH)) u_step (
      .a          (r_a),
      .b          (r_b),
      .ovf_a      (r_ovf_a),
      .ovf_b      (r_ovf_b),
      .next_a     (w_next_a),
      .next_b     (w_next_b),
      .next_ovf_a (w_next_ovf_a),
      .next_ovf_b (w_next_ovf_b)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: start only honoured in IDLE, DONE always lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (w_hs && w_at_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: load seeds on start, advance one term per non-final handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_ovf_a <= 1'b0;
         r_ovf_b <= 1'b0;
         r_idx   <= '0;
         r_n     <= '0;
      end else if (w_start_ok) begin
         r_a     <= seed0;
         r_b     <= seed1;
         r_ovf_a <= 1'b0;
         r_ovf_b <= 1'b0;
         r_idx   <= '0;
         r_n     <= n;
      end else if (w_hs && !w_at_last) begin
         r_a     <= w_next_a;
         r_b     <= w_next_b;
         r_ovf_a <= w_next_ovf_a;
         r_ovf_b <= w_next_ovf_b;
         r_idx   <= r_idx + IDX_W'(1);
      end
   end

   // Sticky overflow: cleared by an accepted start, set by any accepted wrapped term.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_overflow <= 1'b0;
      else if (w_start_ok) r_overflow <= 1'b0;
      else if (w_hs)       r_overflow <= r_overflow | r_ovf_a;
   end

   // Outputs decode straight from registers; nothing combinational from inputs.
   assign busy       = (r_state != IDLE);
   assign term_valid = w_run;
   assign term       = r_a;
   assign term_idx   = r_idx;
   assign term_last  = w_run & w_at_last;
   assign term_ovf   = w_run & r_ovf_a;
   assign done       = (r_state == DONE);
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen (WIDTH=8, IDX_W=4).
module tb_fib_seq_gen;

   logic       clk = 1'b0;
   logic       rst_n, start, term_ready;
   logic [3:0] n;
   logic [7:0] seed0, seed1;
   logic       busy, term_valid, term_last, term_ovf, done, overflow;
   logic [7:0] term;
   logic [3:0] term_idx;

   int checks = 0;
   int passed = 0;

   logic [7:0] cap_term [16];
   logic [3:0] cap_idx  [16];
   logic       cap_last [16];
   logic       cap_ovf  [16];
   int         cap_cnt, done_cnt, done_cyc, last_hs, first_hs, hold_err, last_cnt;
   bit         timed_out;
   logic       post_done, post_busy;

   fib_seq_gen #(.WIDTH(8), .IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n(n), .seed0(seed0), .seed1(seed1),
      .busy(busy), .term_valid(term_valid), .term_ready(term_ready), .term(term),
      .term_idx(term_idx), .term_last(term_last), .term_ovf(term_ovf), .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Issue a one-cycle start; returns at the negedge of the first RUN cycle.
   task automatic do_start(input logic [3:0] tn, input logic [7:0] s0, input logic [7:0] s1);
      @(negedge clk);
      start = 1'b1; n = tn; seed0 = s0; seed1 = s1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive term_ready and record every accepted term until one cycle after done.
   task automatic collect(input bit toggle, input int budget);
      bit         prev_hold = 0;
      logic [7:0] pt = '0;
      logic [3:0] pi = '0;
      logic       pl = 1'b0, po = 1'b0;
      cap_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1; first_hs = -1;
      hold_err = 0; last_cnt = 0; timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            if (term_valid !== 1'b0) hold_err++;
         end
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            post_done = done; post_busy = busy; timed_out = 1'b0;
            break;
         end
         if (prev_hold && (term_valid !== 1'b1 || term !== pt || term_idx !== pi ||
                           term_last !== pl || term_ovf !== po)) hold_err++;
         term_ready = toggle ? ((c % 3) == 0) : 1'b1;
         if (term_valid === 1'b1 && term_ready) begin
            if (cap_cnt < 16) begin
               cap_term[cap_cnt] = term; cap_idx[cap_cnt] = term_idx;
               cap_last[cap_cnt] = term_last; cap_ovf[cap_cnt] = term_ovf;
            end
            if (term_last === 1'b1) last_cnt++;
            cap_cnt++;
            if (first_hs < 0) first_hs = c;
            last_hs = c;
         end
         prev_hold = (term_valid === 1'b1) && !term_ready;
         pt = term; pi = term_idx; pl = term_last; po = term_ovf;
         @(negedge clk);
      end
      term_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; term_ready = 1'b1; n = '0; seed0 = '0; seed1 = '0;
      repeat (3) @(negedge clk);
      checks++; if ({busy, term_valid, done} !== 3'b000)
         $display("FAIL reset_ctrl got %b exp 000", {busy, term_valid, done}); else passed++;
      checks++; if ({term, term_idx} !== 12'h000)
         $display("FAIL reset_data got %h exp 000", {term, term_idx}); else passed++;
      checks++; if ({term_last, term_ovf, overflow} !== 3'b000)
         $display("FAIL reset_flags got %b exp 000", {term_last, term_ovf, overflow}); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] e [7] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
      do_start(4'd6, 8'd0, 8'd1);
      checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else passed++;
      collect(1'b0, 40);
      checks++; if (timed_out) $display("FAIL basic_timeout got 1 exp 0"); else passed++;
      checks++; if (cap_cnt !== 7) $display("FAIL basic_count got %0d exp 7", cap_cnt); else passed++;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_term[i] !== e[i] || cap_idx[i] !== 4'(i) || cap_ovf[i] !== 1'b0 ||
             cap_last[i] !== (i == 6))
            $display("FAIL basic_term%0d got %0d/%0d/%b/%b exp %0d/%0d/0/%b", i,
                     cap_term[i], cap_idx[i], cap_last[i], cap_ovf[i], e[i], i, (i == 6));
         else passed++;
      end
      checks++; if (last_cnt !== 1) $display("FAIL basic_lastcnt got %0d exp 1", last_cnt); else passed++;
      checks++; if (first_hs !== 0 || last_hs !== 6)
         $display("FAIL basic_timing got %0d..%0d exp 0..6", first_hs, last_hs); else passed++;
      checks++; if (done_cyc !== 7 || done_cnt !== 1)
         $display("FAIL basic_done got cyc %0d cnt %0d exp 7 1", done_cyc, done_cnt); else passed++;
      checks++; if (post_busy !== 1'b0 || post_done !== 1'b0)
         $display("FAIL basic_idle got %b%b exp 00", post_busy, post_done); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf got %b exp 0", overflow); else passed++;
   endtask

   task automatic test_backpressure();
      logic [7:0] e [7] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
      do_start(4'd6, 8'd0, 8'd1);
      collect(1'b1, 80);
      checks++; if (timed_out) $display("FAIL bp_timeout got 1 exp 0"); else passed++;
      checks++; if (cap_cnt !== 7) $display("FAIL bp_count got %0d exp 7", cap_cnt); else passed++;
      checks++; if (hold_err !== 0) $display("FAIL bp_hold got %0d exp 0", hold_err); else passed++;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_term[i] !== e[i] || cap_idx[i] !== 4'(i))
            $display("FAIL bp_term%0d got %0d/%0d exp %0d/%0d", i, cap_term[i], cap_idx[i], e[i], i);
         else passed++;
      end
      checks++; if (done_cnt !== 1) $display("FAIL bp_done got %0d exp 1", done_cnt); else passed++;
   endtask

   task automatic test_overflow();
      do_start(4'd14, 8'd0, 8'd1);
      collect(1'b0, 60);
      checks++; if (timed_out || cap_cnt !== 15)
         $display("FAIL ovf_count got %0d exp 15", cap_cnt); else passed++;
      checks++; if (cap_term[13] !== 8'd233 || cap_ovf[13] !== 1'b0 || cap_last[13] !== 1'b0)
         $display("FAIL ovf_idx13 got %0d/%b/%b exp 233/0/0", cap_term[13], cap_ovf[13], cap_last[13]);
      else passed++;
      checks++; if (cap_term[14] !== 8'd121 || cap_ovf[14] !== 1'b1 || cap_last[14] !== 1'b1 ||
                    cap_idx[14] !== 4'd14)
         $display("FAIL ovf_idx14 got %0d/%b/%b exp 121/1/1", cap_term[14], cap_ovf[14], cap_last[14]);
      else passed++;
      checks++; if (cap_ovf[12] !== 1'b0)
         $display("FAIL ovf_idx12 got %b exp 0", cap_ovf[12]); else passed++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passed++;
   endtask

   task automatic test_n0();
      do_start(4'd0, 8'd7, 8'd9);
      checks++; if (overflow !== 1'b0) $display("FAIL n0_ovf_clear got %b exp 0", overflow); else passed++;
      // Stall the consumer and fire a conflicting start while running.
      term_ready = 1'b0;
      start = 1'b1; n = 4'd5; seed0 = 8'd3; seed1 = 8'd3;
      @(negedge clk);
      start = 1'b0;
      checks++; if (term_valid !== 1'b1 || term !== 8'd7 || term_idx !== 4'd0 || term_last !== 1'b1)
         $display("FAIL n0_ignore got %b/%0d/%0d/%b exp 1/7/0/1", term_valid, term, term_idx, term_last);
      else passed++;
      collect(1'b0, 20);
      checks++; if (timed_out || cap_cnt !== 1)
         $display("FAIL n0_count got %0d exp 1", cap_cnt); else passed++;
      checks++; if (cap_term[0] !== 8'd7 || cap_last[0] !== 1'b1)
         $display("FAIL n0_term got %0d/%b exp 7/1", cap_term[0], cap_last[0]); else passed++;
      checks++; if (done_cnt !== 1 || post_busy !== 1'b0)
         $display("FAIL n0_done got %0d/%b exp 1/0", done_cnt, post_busy); else passed++;
   endtask

   task automatic test_reset_midrun();
      int dseen = 0;
      logic [7:0] e [6] = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7, 8'd11};
      do_start(4'd10, 8'd0, 8'd1);
      term_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (term_idx !== 4'd3 || term !== 8'd2)
         $display("FAIL mid_pre got %0d/%0d exp 3/2", term_idx, term); else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({busy, term_valid, done, term_last, term_ovf, overflow} !== 6'b0 ||
                    term !== 8'd0 || term_idx !== 4'd0)
         $display("FAIL mid_async got %b/%0d/%0d exp 0/0/0",
                  {busy, term_valid, done, term_last, term_ovf, overflow}, term, term_idx);
      else passed++;
      repeat (2) begin @(negedge clk); if (done === 1'b1) dseen++; end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) dseen++; end
      checks++; if (dseen !== 0) $display("FAIL mid_nodone got %0d exp 0", dseen); else passed++;
      do_start(4'd5, 8'd2, 8'd1);
      collect(1'b0, 40);
      checks++; if (timed_out || cap_cnt !== 6)
         $display("FAIL mid_count got %0d exp 6", cap_cnt); else passed++;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (cap_term[i] !== e[i] || cap_idx[i] !== 4'(i))
            $display("FAIL mid_term%0d got %0d/%0d exp %0d/%0d", i, cap_term[i], cap_idx[i], e[i], i);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_n0();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised Fibonacci sequence generator, successor to the fixed 8-bit, free-running two-register generator. Runs on command with run-time term count and seeds. Streams every term over a valid/ready interface with index, last-term and per-term overflow flags, then signals completion. Sits between a control/CSR master that issues `start` and a downstream consumer of the term stream.

## Interface
- `WIDTH`, 8, term width in bits (≥2)
- `IDX_W`, 4, index width; the highest requestable index is 2^IDX_W−1
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle run request; sampled only in IDLE.
- `n` input IDX_W: index of the final term; latched on an accepted `start`.
- `seed0` input WIDTH: term 0; latched on an accepted `start`.
- `seed1` input WIDTH: term 1; latched on an accepted `start`.
- `busy` output 1: high in RUN and DONE.
- `term_valid` output 1: a term is presented.
- `term_ready` input 1: consumer accepts the term.
- `term` output WIDTH: term value, modulo 2^WIDTH.
- `term_idx` output IDX_W: index of the presented term.
- `term_last` output 1: presented term is index `n`.
- `term_ovf` output 1: presented term wrapped (it, or an ancestor, carried out).
- `done` output 1: one-cycle pulse after the last handshake.
- `overflow` output 1: sticky OR of every accepted `term_ovf` in the current run; cleared on an accepted `start`.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - `start`=1 latches `n`, sets a←seed0, b←seed1, idx←0, ovf_a←0, ovf_b←0, clears `overflow`, and moves to RUN.
- **RUN:**
  - `term_valid`=1; `term`=a, `term_idx`=idx, `term_ovf`=ovf_a, `term_last`=(idx==n).
  - Handshake is `term_valid & term_ready`. Without a handshake, all outputs hold stable.
  - Handshake with idx≠n advances the sequence: a←b, b←a+b (WIDTH bits, carry discarded), ovf_a←ovf_b, ovf_b←carry|ovf_a|ovf_b, idx←idx+1.
  - Handshake with idx==n moves to DONE.
  - Every handshake ORs `term_ovf` into `overflow`.
- **DONE:**
  - `done`=1 for exactly one cycle, `term_valid`=0, then unconditional move to IDLE.
- `start` in RUN or DONE is ignored; there is no queueing.
- `n`=0 emits only seed0, with `term_last`=1. `n`=1 emits seed0 then seed1.
- An overflow does not stop the run; wrapped values continue to be emitted.
- idx never wraps, because the run stops at idx==n ≤ 2^IDX_W−1.

## Timing
- All outputs are registered or decoded directly from state registers. There is no combinational path from any input to any output.
- Reset values: `busy`, `term_valid`, `term_last`, `term_ovf`, `done` and `overflow` are 0. `term` and `term_idx` are 0. Internal a, b, idx and n are 0.
- `start` accepted on edge k: `term_valid`=1 from cycle k+1.
- With `term_ready` held high, one term is produced per cycle. A run of n+1 terms occupies cycles k+1..k+n+1, `done` is high in cycle k+n+2, and IDLE is reached at k+n+3.
- The earliest next `start` is accepted in cycle k+n+3.
- `rst_n` low mid-run immediately forces IDLE and the reset values, with no `done` pulse. The in-flight term is lost.

## Structure
- Package `fib_pkg` holds the state enum `fib_state_e` {IDLE, RUN, DONE}.
- Sub-module `fib_step`:
  - Combinational.
  - Inputs: a, b, ovf_a, ovf_b.
  - Outputs: next_a, next_b, next_ovf_a, next_ovf_b.
  - WIDTH-parametrised.
  - Reused by the sibling Lucas/seeded generators.
- The top level holds the FSM, the datapath registers, the index counter and the sticky flag.

## Test plan
- WIDTH=8, `n`=6, seeds 0/1, `term_ready`=1:
  - Terms are 0,1,1,2,3,5,8 with idx 0..6.
  - `term_last` is high only on 8.
  - `done` pulses one cycle later.
  - `overflow`=0.
- Same run with `term_ready` toggling 1,0,0,1,…:
  - Values are identical.
  - Outputs hold stable while ready=0.
  - No term is dropped or duplicated.
- WIDTH=8, `n`=14, seeds 0/1:
  - Idx 13 gives 233 with `term_ovf`=0.
  - Idx 14 gives 121 with `term_ovf`=1 and `term_last`=1.
  - `overflow`=1 after the run. The next `start` clears it.
- `n`=0, seeds 7/9:
  - A single term, 7, idx 0, with `term_last`=1.
  - `done` pulses.
  - `start` during RUN is ignored (the term count is unchanged).
- `rst_n` pulsed low mid-run at idx 3:
  - Outputs return to 0 asynchronously and the FSM is in IDLE.
  - No `done` pulse.
  - A subsequent `start` with seeds 2/1 gives 2,1,3,4,….
